puvvada_says_seq: RTL

- Colour-sequence store and checker for the Simon game; sits directly upstream of the game state machine.
- Appends pseudo-random colours (16-bit LFSR) to an on-chip sequence memory.
- Plays the sequence back one step at a time as a one-hot colour code for LEDs/SSD.
- Compares player button presses against the stored sequence and reports match, mismatch and round completion.

---
 rtl/puvvada_says_seq_if.sv | 31 +++
 rtl/puvvada_says_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/puvvada_says_seq_if.sv
// Handshake bundle between the Simon game state machine and the sequence store.
// The master drives commands and button presses, and the slave returns playback and check results.
interface puvvada_says_seq_if;
    logic        clear;
    logic        seed_load;
    logic [15:0] seed;
    logic        append;
    logic        play_start;
    logic        step;
    logic        btn_valid;
    logic [3:0]  btn_code;
    logic [3:0]  play_color;
    logic        play_valid;
    logic        play_done;
    logic        match;
    logic        mismatch;
    logic        round_done;
    logic [6:0]  length;
    logic        full;
    logic        busy;

    modport master (
        output clear, seed_load, seed, append, play_start, step, btn_valid, btn_code,
        input  play_color, play_valid, play_done, match, mismatch, round_done, length, full, busy
    );

    modport slave (
        input  clear, seed_load, seed, append, play_start, step, btn_valid, btn_code,
        output play_color, play_valid, play_done, match, mismatch, round_done, length, full, busy
    );
endinterface

// File: rtl/puvvada_says_seq.sv
// Simon colour-sequence store. It appends colours from a free-running Galois LFSR,
// plays the sequence back one entry per step, and checks the player's presses against it.
module puvvada_says_seq #(
    parameter int                MAX_LEN      = 64,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1
) (
    input logic              clk,
    input logic              rst_n,
    puvvada_says_seq_if.slave bus
);
    localparam int                IDX_W    = $clog2(MAX_LEN);
    localparam logic [6:0]        LEN_MAX  = 7'(MAX_LEN);
    localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

    typedef enum logic [1:0] {IDLE, PLAY, CHECK} state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [6:0]        length, length_n;
    logic [LFSR_W-1:0] lfsr;
    logic [1:0]        mem [MAX_LEN];
    logic              mem_we;
    logic              is_last;
    logic [3:0]        expected_code;

    logic [3:0] play_color_q, play_color_n;
    logic       play_valid_q, play_valid_n;
    logic       play_done_q, play_done_n;
    logic       match_q, match_n;
    logic       mismatch_q, mismatch_n;
    logic       round_done_q, round_done_n;
    logic       full_q, full_n;
    logic       busy_q, busy_n;

    function automatic logic [3:0] onehot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

    // A zero seed would lock the LFSR at zero, so it is replaced by the default seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_DEFAULT;
        end else if (bus.seed_load) begin
            lfsr <= (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
        end else begin
            lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAP_MASK : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[length[IDX_W-1:0]] <= lfsr[1:0];
        end
    end

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        length_n     = length;
        mem_we       = 1'b0;
        play_done_n  = 1'b0;
        match_n      = 1'b0;
        mismatch_n   = 1'b0;
        round_done_n = 1'b0;
        is_last       = (7'(idx) == length - 7'd1);
        expected_code = onehot(mem[idx]);

        if (bus.clear) begin
            state_n  = IDLE;
            idx_n    = '0;
            length_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.append) begin
                        if (length < LEN_MAX) begin
                            mem_we   = 1'b1;
                            length_n = length + 7'd1;
                        end
                    end else if (bus.play_start && length != 7'd0) begin
                        state_n = PLAY;
                        idx_n   = '0;
                    end
                end
                PLAY: begin
                    if (bus.step) begin
                        if (is_last) begin
                            state_n     = CHECK;
                            idx_n       = '0;
                            play_done_n = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (bus.btn_valid) begin
                        if (bus.btn_code == expected_code) begin
                            match_n = 1'b1;
                            if (is_last) begin
                                round_done_n = 1'b1;
                                idx_n        = '0;
                                state_n      = IDLE;
                            end else begin
                                idx_n = idx + 1'b1;
                            end
                        end else begin
                            mismatch_n = 1'b1;
                            idx_n      = '0;
                            state_n    = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                end
            endcase
        end

        // Playback outputs look ahead to the next state so the colour is registered in step with it.
        play_valid_n = (state_n == PLAY);
        play_color_n = play_valid_n ? onehot(mem[idx_n]) : 4'b0000;
        full_n       = (length_n == LEN_MAX);
        busy_n       = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            length <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            length <= length_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_color_q <= '0;
            play_valid_q <= 1'b0;
            play_done_q  <= 1'b0;
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            round_done_q <= 1'b0;
            full_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            play_color_q <= play_color_n;
            play_valid_q <= play_valid_n;
            play_done_q  <= play_done_n;
            match_q      <= match_n;
            mismatch_q   <= mismatch_n;
            round_done_q <= round_done_n;
            full_q       <= full_n;
            busy_q       <= busy_n;
        end
    end

    assign bus.play_color = play_color_q;
    assign bus.play_valid = play_valid_q;
    assign bus.play_done  = play_done_q;
    assign bus.match      = match_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.round_done = round_done_q;
    assign bus.length     = length;
    assign bus.full       = full_q;
    assign bus.busy       = busy_q;
endmodule
